gpu_instruction_scheduler: RTL and testbench
============================================

Name: gpu_instruction_scheduler

Overview:
- Sits between the GPU instruction decoder and the draw engines (line, rect).
- Holds shadow parameter registers (xy1, xy2, radius) written by the decoder's set_* commands.
- On each draw command, snapshots the shadow registers and colour into a small instruction FIFO.
- Dispatches one instruction at a time to the matching engine with a start/done handshake, so the host can queue draws while an engine is busy.

Parameters:
- WIDTH_BITS, 10, x coordinate and radius width.
- HEIGHT_BITS, 9, y coordinate width.
- CHANNEL_BITS, 8, width of one colour channel.
- FIFO_DEPTH, 4, instruction queue entries; must be a power of 2, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- command_i  in  1  decoder command strobe.
- opcode_i  in  4  decoder opcode.
- x1_i, x2_i  in  WIDTH_BITS  decoded x values.
- y1_i, y2_i  in  HEIGHT_BITS  decoded y values.
- rad_i  in  WIDTH_BITS  decoded radius.
- r_i, g_i, b_i  in  CHANNEL_BITS  decoded colour.
- write_enable_i  in  1  decoder write enable.
- push_instruction_i  in  1  decoder push request.
- engine_done_i  in  1  one-cycle pulse from the active engine when its draw completes.
- line_start_o  out  1  one-cycle start pulse to the line engine.
- rect_start_o  out  1  one-cycle start pulse to the rect engine.
- x1_o, x2_o  out  WIDTH_BITS  dispatched x values.
- y1_o, y2_o  out  HEIGHT_BITS  dispatched y values.
- rad_o  out  WIDTH_BITS  dispatched radius.
- r_o, g_o, b_o  out  CHANNEL_BITS  dispatched colour.
- engine_abort_o  out  1  one-cycle pulse on soft reset.
- fifo_full_o  out  1  count == FIFO_DEPTH.
- overflow_o  out  1  sticky: a push was dropped.
- busy_o  out  1  FSM not IDLE, or FIFO not empty.

Behaviour:
- Reset (rst=1, asynchronous): all outputs 0, shadow registers 0, FIFO empty (pointers and count 0), FSM in IDLE.
- Shadow writes (command_i & write_enable_i), one cycle, visible on the next edge:
  - opcode 0001 loads x1, y1.
  - opcode 0010 loads x2, y2.
  - opcode 0011 loads rad.
- Enqueue: command_i & push_instruction_i & opcode in {0100 line, 0101 rect}.
  - Writes entry {type, shadow x1, y1, x2, y2, rad, r_i, g_i, b_i} at the write pointer.
  - Shadow values are those held before the edge; the shadow registers themselves are unchanged.
- Push while full with no same-cycle pop: entry dropped, overflow_o set to 1 and held until rst or soft reset.
- Push while full with a same-cycle pop: push accepted, count unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count is updated by +1 (push only), −1 (pop only) or 0 (both or neither).
- Soft reset (command_i & opcode 0000), synchronous, takes priority over every other action that cycle:
  - flush the FIFO and clear the shadow registers;
  - clear overflow_o and force the FSM to IDLE;
  - engine_abort_o=1 for the following cycle;
  - data outputs keep their values; start outputs are 0.
- Opcodes 0110–1111 are ignored.
- FSM IDLE:
  - If the FIFO is non-empty: pop the head into the output registers and go to ISSUE.
  - Otherwise stay in IDLE.
- FSM ISSUE (exactly one cycle):
  - Assert line_start_o or rect_start_o per the entry type, then go to WAIT.
  - Output data is stable from ISSUE through WAIT.
- FSM WAIT:
  - On engine_done_i, go to IDLE.
  - engine_done_i is ignored in IDLE and ISSUE.
- Latency: push at edge N → pop at edge N+1 (FSM idle) → start pulse high during cycle N+1..N+2.
- Back-to-back draws: done → IDLE (1 cycle) → ISSUE, giving 2 cycles from done to the next start pulse.
- At most one start pulse is high at any time, and never two pulses in consecutive cycles.

Decomposition:
- Shared package gpu_sched_pkg:
  - opcode constants (OP_RESET, OP_SET_XY1, OP_SET_XY2, OP_SET_RAD, OP_DRAW_LINE, OP_DRAW_RECT);
  - enum instr_type_t {LINE, RECT};
  - struct instr_t (the entry fields);
  - enum sched_state_t {IDLE, ISSUE, WAIT}.
- One sub-module: gpu_instr_fifo, a parameterized synchronous FIFO of instr_t with push/pop, full/empty, count and flush.

Test Plan:
- Set and draw: set_xy1 (x=10, y=20), set_xy2 (x=100, y=200), draw_line rgb=(0xFF, 0x00, 0x80).
  - Required: one line_start_o pulse 2 cycles after the push.
  - Required outputs: x1=10, y1=20, x2=100, y2=200, r=0xFF, g=0x00, b=0x80.
- Queue during busy: push rect then line while engine_done_i is held low.
  - Required: only rect_start_o fires.
  - After a done pulse, line_start_o fires 2 cycles later with the second snapshot.
- Overflow: with the engine never done, push 6 draws (DEPTH=4).
  - First pops, next 4 fill the FIFO: fifo_full_o=1.
  - 6th push dropped: overflow_o=1 and stays 1.
- Full plus pop: full FIFO, done pulse and push in the same cycle.
  - Required: push accepted, fifo_full_o stays 1, overflow_o stays 0.
- Soft reset mid-draw: opcode 0000 while in WAIT with 2 entries queued.
  - Required: engine_abort_o pulses, busy_o=0 the next cycle, overflow_o=0, no further start pulses.
- Async reset: rst asserted between clock edges during ISSUE.
  - Required: all outputs 0 immediately, and no start pulse after rst is released.

Source files
------------

// File: rtl/gpu_sched_pkg.sv
// rtl/gpu_sched_pkg.sv - shared opcodes, instruction entry layout and scheduler states
package gpu_sched_pkg;

  localparam int unsigned INSTR_X_BITS = 10;
  localparam int unsigned INSTR_Y_BITS = 9;
  localparam int unsigned INSTR_C_BITS = 8;

  localparam logic [3:0] OP_RESET     = 4'b0000;
  localparam logic [3:0] OP_SET_XY1   = 4'b0001;
  localparam logic [3:0] OP_SET_XY2   = 4'b0010;
  localparam logic [3:0] OP_SET_RAD   = 4'b0011;
  localparam logic [3:0] OP_DRAW_LINE = 4'b0100;
  localparam logic [3:0] OP_DRAW_RECT = 4'b0101;

  typedef enum logic {LINE = 1'b0, RECT = 1'b1} instr_type_t;

  typedef struct packed {
    logic [INSTR_X_BITS-1:0] x1;
    logic [INSTR_Y_BITS-1:0] y1;
    logic [INSTR_X_BITS-1:0] x2;
    logic [INSTR_Y_BITS-1:0] y2;
    logic [INSTR_X_BITS-1:0] rad;
    logic [INSTR_C_BITS-1:0] r;
    logic [INSTR_C_BITS-1:0] g;
    logic [INSTR_C_BITS-1:0] b;
  } instr_data_t;

  typedef struct packed {
    instr_type_t kind;
    instr_data_t data;
  } instr_t;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} sched_state_t;

endpackage

// File: rtl/gpu_instruction_scheduler_fifo.sv
// rtl/gpu_instruction_scheduler_fifo.sv - synchronous instruction FIFO with flush
module gpu_instr_fifo
  import gpu_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  instr_t                   push_data_i,
  output instr_t                   pop_data_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);

  instr_t              mem_q [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS:0]   count_q, count_d;
  logic                empty;
  logic                do_push;
  logic                do_pop;

  assign empty      = (count_q == '0);
  assign full_o     = (count_q == (PTR_BITS+1)'(DEPTH));
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A pop frees a slot in the same edge, so a full FIFO still accepts a push then.
  always_comb begin
    do_pop   = pop_i && !empty;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/gpu_instruction_scheduler.sv
// rtl/gpu_instruction_scheduler.sv - shadow parameter registers, draw queue and engine dispatch
module gpu_instruction_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int unsigned WIDTH_BITS   = INSTR_X_BITS,
  parameter int unsigned HEIGHT_BITS  = INSTR_Y_BITS,
  parameter int unsigned CHANNEL_BITS = INSTR_C_BITS,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    command_i,
  input  logic [3:0]              opcode_i,
  input  logic [WIDTH_BITS-1:0]   x1_i,
  input  logic [WIDTH_BITS-1:0]   x2_i,
  input  logic [HEIGHT_BITS-1:0]  y1_i,
  input  logic [HEIGHT_BITS-1:0]  y2_i,
  input  logic [WIDTH_BITS-1:0]   rad_i,
  input  logic [CHANNEL_BITS-1:0] r_i,
  input  logic [CHANNEL_BITS-1:0] g_i,
  input  logic [CHANNEL_BITS-1:0] b_i,
  input  logic                    write_enable_i,
  input  logic                    push_instruction_i,
  input  logic                    engine_done_i,
  output logic                    line_start_o,
  output logic                    rect_start_o,
  output logic [WIDTH_BITS-1:0]   x1_o,
  output logic [WIDTH_BITS-1:0]   x2_o,
  output logic [HEIGHT_BITS-1:0]  y1_o,
  output logic [HEIGHT_BITS-1:0]  y2_o,
  output logic [WIDTH_BITS-1:0]   rad_o,
  output logic [CHANNEL_BITS-1:0] r_o,
  output logic [CHANNEL_BITS-1:0] g_o,
  output logic [CHANNEL_BITS-1:0] b_o,
  output logic                    engine_abort_o,
  output logic                    fifo_full_o,
  output logic                    overflow_o,
  output logic                    busy_o
);

  sched_state_t          state_q, state_d;
  instr_data_t           out_q, out_d;
  logic                  line_start_q, line_start_d;
  logic                  rect_start_q, rect_start_d;
  logic                  abort_q, abort_d;
  logic                  overflow_q, overflow_d;
  logic [WIDTH_BITS-1:0] sx1_q, sx1_d, sx2_q, sx2_d, srad_q, srad_d;
  logic [HEIGHT_BITS-1:0] sy1_q, sy1_d, sy2_q, sy2_d;

  logic                      soft_reset, push_req, pop_req, fifo_empty, fifo_full;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  instr_t                    fifo_wdata, fifo_head;

  assign soft_reset = command_i && (opcode_i == OP_RESET);
  assign push_req   = command_i && push_instruction_i &&
                      ((opcode_i == OP_DRAW_LINE) || (opcode_i == OP_DRAW_RECT));
  assign fifo_empty = (fifo_count == '0);
  assign pop_req    = (state_q == IDLE) && !fifo_empty && !soft_reset;

  // The snapshot takes the shadow values held before this edge.
  always_comb begin
    fifo_wdata.kind     = (opcode_i == OP_DRAW_RECT) ? RECT : LINE;
    fifo_wdata.data.x1  = sx1_q;
    fifo_wdata.data.y1  = sy1_q;
    fifo_wdata.data.x2  = sx2_q;
    fifo_wdata.data.y2  = sy2_q;
    fifo_wdata.data.rad = srad_q;
    fifo_wdata.data.r   = r_i;
    fifo_wdata.data.g   = g_i;
    fifo_wdata.data.b   = b_i;
  end

  gpu_instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (soft_reset),
    .push_i      (push_req),
    .pop_i       (pop_req),
    .push_data_i (fifo_wdata),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  always_comb begin
    sx1_d  = sx1_q;
    sy1_d  = sy1_q;
    sx2_d  = sx2_q;
    sy2_d  = sy2_q;
    srad_d = srad_q;
    if (soft_reset) begin
      sx1_d  = '0;
      sy1_d  = '0;
      sx2_d  = '0;
      sy2_d  = '0;
      srad_d = '0;
    end else if (command_i && write_enable_i) begin
      case (opcode_i)
        OP_SET_XY1: begin sx1_d = x1_i; sy1_d = y1_i; end
        OP_SET_XY2: begin sx2_d = x2_i; sy2_d = y2_i; end
        OP_SET_RAD: srad_d = rad_i;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    line_start_d = 1'b0;
    rect_start_d = 1'b0;
    abort_d      = 1'b0;
    overflow_d   = overflow_q;
    if (soft_reset) begin
      state_d    = IDLE;
      abort_d    = 1'b1;
      overflow_d = 1'b0;
    end else begin
      if (push_req && fifo_full && !pop_req) overflow_d = 1'b1;
      case (state_q)
        IDLE: if (pop_req) begin
          out_d        = fifo_head.data;
          line_start_d = (fifo_head.kind == LINE);
          rect_start_d = (fifo_head.kind == RECT);
          state_d      = ISSUE;
        end
        ISSUE:   state_d = WAIT;
        WAIT:    if (engine_done_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      out_q        <= '0;
      line_start_q <= 1'b0;
      rect_start_q <= 1'b0;
      abort_q      <= 1'b0;
      overflow_q   <= 1'b0;
      sx1_q        <= '0;
      sy1_q        <= '0;
      sx2_q        <= '0;
      sy2_q        <= '0;
      srad_q       <= '0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      line_start_q <= line_start_d;
      rect_start_q <= rect_start_d;
      abort_q      <= abort_d;
      overflow_q   <= overflow_d;
      sx1_q        <= sx1_d;
      sy1_q        <= sy1_d;
      sx2_q        <= sx2_d;
      sy2_q        <= sy2_d;
      srad_q       <= srad_d;
    end
  end

  assign line_start_o   = line_start_q;
  assign rect_start_o   = rect_start_q;
  assign x1_o           = out_q.x1;
  assign y1_o           = out_q.y1;
  assign x2_o           = out_q.x2;
  assign y2_o           = out_q.y2;
  assign rad_o          = out_q.rad;
  assign r_o            = out_q.r;
  assign g_o            = out_q.g;
  assign b_o            = out_q.b;
  assign engine_abort_o = abort_q;
  assign fifo_full_o    = fifo_full;
  assign overflow_o     = overflow_q;
  assign busy_o         = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_gpu_instruction_scheduler.sv
// tb/tb_gpu_instruction_scheduler.sv - directed self-checking bench for the instruction scheduler
module tb_gpu_instruction_scheduler;
  import gpu_sched_pkg::*;

  logic       clk, rst, command_i, write_enable_i, push_instruction_i, engine_done_i;
  logic [3:0] opcode_i;
  logic [9:0] x1_i, x2_i, rad_i, x1_o, x2_o, rad_o;
  logic [8:0] y1_i, y2_i, y1_o, y2_o;
  logic [7:0] r_i, g_i, b_i, r_o, g_o, b_o;
  logic       line_start_o, rect_start_o, engine_abort_o, fifo_full_o, overflow_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  gpu_instruction_scheduler #(
    .WIDTH_BITS(10), .HEIGHT_BITS(9), .CHANNEL_BITS(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .command_i(command_i), .opcode_i(opcode_i),
    .x1_i(x1_i), .x2_i(x2_i), .y1_i(y1_i), .y2_i(y2_i), .rad_i(rad_i),
    .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .write_enable_i(write_enable_i), .push_instruction_i(push_instruction_i),
    .engine_done_i(engine_done_i),
    .line_start_o(line_start_o), .rect_start_o(rect_start_o),
    .x1_o(x1_o), .x2_o(x2_o), .y1_o(y1_o), .y2_o(y2_o), .rad_o(rad_o),
    .r_o(r_o), .g_o(g_o), .b_o(b_o),
    .engine_abort_o(engine_abort_o), .fifo_full_o(fifo_full_o),
    .overflow_o(overflow_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Each step presents one cycle of decoder inputs and returns at the following negedge.
  task automatic step(input logic cmd, input logic [3:0] op, input logic we,
                      input logic push, input logic done);
    command_i = cmd; opcode_i = op; write_enable_i = we;
    push_instruction_i = push; engine_done_i = done;
    @(negedge clk);
    command_i = 1'b0; opcode_i = 4'h0; write_enable_i = 1'b0;
    push_instruction_i = 1'b0; engine_done_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic done_pulse();
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic set_xy1(input logic [9:0] x, input logic [8:0] y);
    x1_i = x; y1_i = y;
    step(1'b1, OP_SET_XY1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_xy2(input logic [9:0] x, input logic [8:0] y);
    x2_i = x; y2_i = y;
    step(1'b1, OP_SET_XY2, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_rad(input logic [9:0] rv);
    rad_i = rv;
    step(1'b1, OP_SET_RAD, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic draw(input logic [3:0] op, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b);
    r_i = r; g_i = g; b_i = b;
    step(1'b1, op, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic soft_reset();
    step(1'b1, OP_RESET, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; command_i = 0; opcode_i = 0; write_enable_i = 0;
    push_instruction_i = 0; engine_done_i = 0;
    x1_i = 0; x2_i = 0; y1_i = 0; y2_i = 0; rad_i = 0; r_i = 0; g_i = 0; b_i = 0;
    repeat (2) @(negedge clk);
    check_eq("rst line_start", line_start_o, 0);
    check_eq("rst rect_start", rect_start_o, 0);
    check_eq("rst busy", busy_o, 0);
    check_eq("rst full", fifo_full_o, 0);
    check_eq("rst overflow", overflow_o, 0);
    check_eq("rst abort", engine_abort_o, 0);
    check_eq("rst x1", x1_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // Reserved opcode with push set must not enqueue.
    r_i = 8'h11;
    step(1'b1, 4'b0110, 1'b1, 1'b1, 1'b0);
    check_eq("ignored op busy", busy_o, 0);

    // Set and draw.
    set_xy1(10'd10, 9'd20);
    set_xy2(10'd100, 9'd200);
    set_rad(10'd33);
    draw(OP_DRAW_LINE, 8'hFF, 8'h00, 8'h80);
    check_eq("t1 no start yet", line_start_o, 0);
    check_eq("t1 busy", busy_o, 1);
    idle(1);
    check_eq("t1 line_start", line_start_o, 1);
    check_eq("t1 rect_start", rect_start_o, 0);
    check_eq("t1 x1", x1_o, 10);
    check_eq("t1 y1", y1_o, 20);
    check_eq("t1 x2", x2_o, 100);
    check_eq("t1 y2", y2_o, 200);
    check_eq("t1 rad", rad_o, 33);
    check_eq("t1 r", r_o, 8'hFF);
    check_eq("t1 g", g_o, 8'h00);
    check_eq("t1 b", b_o, 8'h80);
    idle(1);
    check_eq("t1 pulse width", line_start_o, 0);
    check_eq("t1 wait busy", busy_o, 1);
    done_pulse();
    check_eq("t1 done busy", busy_o, 0);

    // Queue during busy: rect snapshot is taken before xy1 changes.
    draw(OP_DRAW_RECT, 8'h01, 8'h02, 8'h03);
    set_xy1(10'd7, 9'd8);
    check_eq("t2 rect_start", rect_start_o, 1);
    check_eq("t2 rect x1", x1_o, 10);
    check_eq("t2 rect r", r_o, 8'h01);
    draw(OP_DRAW_LINE, 8'h04, 8'h05, 8'h06);
    for (int k = 0; k < 3; k++) begin
      check_eq("t2 no line while busy", line_start_o, 0);
      check_eq("t2 no rect repeat", rect_start_o, 0);
      idle(1);
    end
    done_pulse();
    check_eq("t2 idle cycle no start", line_start_o, 0);
    idle(1);
    check_eq("t2 line_start", line_start_o, 1);
    check_eq("t2 line rect_start", rect_start_o, 0);
    check_eq("t2 x1", x1_o, 7);
    check_eq("t2 y1", y1_o, 8);
    check_eq("t2 x2", x2_o, 100);
    check_eq("t2 r", r_o, 8'h04);
    check_eq("t2 b", b_o, 8'h06);
    idle(1);
    done_pulse();
    check_eq("t2 drained", busy_o, 0);

    // Overflow: first draw pops, next four fill, sixth is dropped.
    for (int i = 0; i < 6; i++) begin
      draw(OP_DRAW_LINE, 8'(8'h40 + i), 8'h00, 8'h00);
      if (i == 4) begin
        check_eq("t3 full after 5", fifo_full_o, 1);
        check_eq("t3 no overflow yet", overflow_o, 0);
      end
    end
    check_eq("t3 full", fifo_full_o, 1);
    check_eq("t3 overflow", overflow_o, 1);
    check_eq("t3 dispatched r", r_o, 8'h40);
    idle(2);
    check_eq("t3 overflow sticky", overflow_o, 1);
    soft_reset();
    check_eq("t3 sr abort", engine_abort_o, 1);
    check_eq("t3 sr overflow", overflow_o, 0);
    check_eq("t3 sr busy", busy_o, 0);
    check_eq("t3 sr full", fifo_full_o, 0);
    idle(1);
    check_eq("t3 abort one cycle", engine_abort_o, 0);

    // Full plus pop: the pop happens in the IDLE cycle after done, push lands there.
    for (int i = 0; i < 5; i++) draw(OP_DRAW_LINE, 8'(8'h10 + i), 8'h00, 8'h00);
    check_eq("t4 full", fifo_full_o, 1);
    check_eq("t4 overflow clear", overflow_o, 0);
    done_pulse();
    draw(OP_DRAW_LINE, 8'h15, 8'h00, 8'h00);
    check_eq("t4 full kept", fifo_full_o, 1);
    check_eq("t4 no overflow", overflow_o, 0);
    check_eq("t4 line_start", line_start_o, 1);
    check_eq("t4 r", r_o, 8'h11);
    idle(1);
    done_pulse();
    idle(1);
    check_eq("t4 next r", r_o, 8'h12);
    check_eq("t4 not full", fifo_full_o, 0);
    idle(1);
    done_pulse();
    idle(1);
    check_eq("t4 third r", r_o, 8'h13);
    idle(1);
    set_xy1(10'd55, 9'd66);

    // Soft reset in WAIT with two entries queued.
    soft_reset();
    check_eq("t5 abort", engine_abort_o, 1);
    check_eq("t5 busy", busy_o, 0);
    check_eq("t5 overflow", overflow_o, 0);
    check_eq("t5 no start", line_start_o, 0);
    check_eq("t5 data held", r_o, 8'h13);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      check_eq("t5 abort low", engine_abort_o, 0);
      check_eq("t5 no line", line_start_o, 0);
      check_eq("t5 no rect", rect_start_o, 0);
      check_eq("t5 idle busy", busy_o, 0);
    end

    // Shadow registers were cleared by the soft reset.
    draw(OP_DRAW_LINE, 8'h21, 8'h22, 8'h23);
    idle(1);
    check_eq("t6 issue start", line_start_o, 1);
    check_eq("t6 x1 cleared", x1_o, 0);
    check_eq("t6 y1 cleared", y1_o, 0);
    check_eq("t6 r", r_o, 8'h21);

    // Asynchronous reset between edges during ISSUE.
    #2 rst = 1'b1;
    #1;
    check_eq("t6 async line_start", line_start_o, 0);
    check_eq("t6 async r", r_o, 0);
    check_eq("t6 async g", g_o, 0);
    check_eq("t6 async busy", busy_o, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idle(1);
      check_eq("t6 post rst line", line_start_o, 0);
      check_eq("t6 post rst rect", rect_start_o, 0);
      check_eq("t6 post rst busy", busy_o, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
